// File: rtl/result_accumulator.sv
// Running signed fixed-point accumulator with a sequential int-to-float converter.
// Build with SATURATE_EN defined to clamp the accumulator on overflow instead of wrapping.
module result_accumulator #(
    parameter int CORDIC_DATA_WIDTH = 22,
    parameter int FRAC_BITS         = 16,
    parameter int ACC_WIDTH         = 32,
    parameter int FLT_DATA_WIDTH    = 32,
    parameter int N_WIDTH           = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clk_en,
    input  logic                         i_start,
    input  logic [N_WIDTH-1:0]           i_n,
    input  logic                         i_in_valid,
    input  logic [CORDIC_DATA_WIDTH-1:0] i_in_data,
    output logic [FLT_DATA_WIDTH-1:0]    o_result,
    output logic                         o_done,
    output logic                         o_busy,
    output logic                         o_armed,
    output logic                         o_overflow
);

    localparam int MSB  = ACC_WIDTH - 1;
    localparam int SH_W = $clog2(ACC_WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_NORM = 3'd2;
    localparam logic [2:0] S_PACK = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [N_WIDTH-1:0] CMD_CLEAR = N_WIDTH'(0);
    localparam logic [N_WIDTH-1:0] CMD_GO    = N_WIDTH'(1);
    localparam logic [N_WIDTH-1:0] CMD_READ  = N_WIDTH'(2);

    localparam logic [7:0] EXP_BASE = 8'(127 + ACC_WIDTH - 1 - FRAC_BITS);

    logic [2:0]                  r_state;
    logic [ACC_WIDTH-1:0]        r_acc;
    logic [ACC_WIDTH-1:0]        r_snapshot;
    logic [ACC_WIDTH-1:0]        r_mag;
    logic [SH_W-1:0]             r_sh;
    logic                        r_sign;
    logic                        r_armed;
    logic                        r_overflow;
    logic [FLT_DATA_WIDTH-1:0]   r_result;

    logic                        w_accept;
    logic                        w_clear;
    logic                        w_add;
    logic [ACC_WIDTH-1:0]        w_ext;
    logic [ACC_WIDTH-1:0]        w_sum;
    logic                        w_ovf;
    logic [ACC_WIDTH-1:0]        w_next_acc;
    logic [ACC_WIDTH-1:0]        w_abs;
    logic [7:0]                  w_exp;
    logic [22:0]                 w_mant;

    assign w_accept = i_start && (r_state == S_IDLE);
    assign w_clear  = w_accept && (i_n == CMD_CLEAR);
    assign w_add    = r_armed && i_in_valid;
    assign w_ext    = {{(ACC_WIDTH - CORDIC_DATA_WIDTH){i_in_data[CORDIC_DATA_WIDTH-1]}}, i_in_data};
    assign w_sum    = r_acc + w_ext;
    assign w_ovf    = (r_acc[MSB] == w_ext[MSB]) && (w_sum[MSB] != r_acc[MSB]);

`ifdef SATURATE_EN
    assign w_next_acc = !w_ovf     ? w_sum :
                        r_acc[MSB] ? {1'b1, {MSB{1'b0}}} :
                                     {1'b0, {MSB{1'b1}}};
`else
    assign w_next_acc = w_sum;
`endif

    // Magnitude is taken as unsigned so the most negative value maps to 2^(ACC_WIDTH-1).
    assign w_abs  = r_snapshot[MSB] ? (~r_snapshot + ACC_WIDTH'(1)) : r_snapshot;
    assign w_exp  = EXP_BASE - {{(8 - SH_W){1'b0}}, r_sh};
    assign w_mant = r_mag[ACC_WIDTH-2 -: 23];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_armed    <= 1'b0;
        end else if (i_clk_en) begin
            if (w_clear) begin
                r_acc      <= '0;
                r_overflow <= 1'b0;
            end else if (w_add) begin
                r_acc <= w_next_acc;
                if (w_ovf) begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_accept && (i_n == CMD_GO)) begin
                r_armed <= 1'b1;
            end
        end
    end

    // NORM runs exactly sh cycles: LOAD skips it when the magnitude is already normalised.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_snapshot <= '0;
            r_mag      <= '0;
            r_sh       <= '0;
            r_sign     <= 1'b0;
            r_result   <= '0;
        end else if (i_clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (i_n == CMD_READ)) begin
                        r_snapshot <= r_acc;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_sign <= r_snapshot[MSB];
                    r_mag  <= w_abs;
                    r_sh   <= '0;
                    if (r_snapshot == '0) begin
                        r_result <= '0;
                        r_state  <= S_DONE;
                    end else if (w_abs[MSB]) begin
                        r_state <= S_PACK;
                    end else begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_mag <= r_mag << 1;
                    r_sh  <= r_sh + SH_W'(1);
                    if (r_mag[MSB-1]) begin
                        r_state <= S_PACK;
                    end
                end
                S_PACK: begin
                    r_result <= FLT_DATA_WIDTH'({r_sign, w_exp, w_mant});
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_result   = r_result;
    assign o_done     = (r_state == S_DONE);
    assign o_busy     = (r_state != S_IDLE);
    assign o_armed    = r_armed;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_result_accumulator.sv
// Directed and randomized bench for result_accumulator, checked cycle by cycle
// against a value-level model that converts through the simulator's real type.
module tb_result_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clkEn;
    logic        start;
    logic [1:0]  n;
    logic        inValid;
    logic [21:0] inData;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        armed;
    logic        overflow;

    int nAsserts = 0;
    int nFails   = 0;

    // Reference model state
    logic signed [31:0] mAcc;
    bit                 mArmed;
    bit                 mOvf;
    bit                 mPending;
    int                 mCount;
    int                 mLat;
    logic [31:0]        mResult;
    logic [31:0]        mNewRes;

    result_accumulator dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clk_en   (clkEn),
        .i_start    (start),
        .i_n        (n),
        .i_in_valid (inValid),
        .i_in_data  (inData),
        .o_result   (result),
        .o_done     (done),
        .o_busy     (busy),
        .o_armed    (armed),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    // Float of acc/2^16 via double precision, truncated to single; latency from the exponent.
    function automatic void floatOf(input logic signed [31:0] a, output logic [31:0] f, output int lat);
        real         r;
        logic [63:0] b;
        int          e;
        if (a == 0) begin
            f   = 32'h0;
            lat = 2;
        end else begin
            r   = $itor(a) / 65536.0;
            b   = $realtobits(r);
            e   = int'(b[62:52]) - 1023;
            f   = {b[63], 8'(e + 127), b[51:29]};
            lat = 3 + (15 - e);
        end
    endfunction

    function automatic void modelReset();
        mAcc     = 0;
        mArmed   = 0;
        mOvf     = 0;
        mPending = 0;
        mCount   = 0;
        mLat     = 0;
        mResult  = 32'h0;
        mNewRes  = 32'h0;
    endfunction

    function automatic void modelStep(input bit en, input bit st, input logic [1:0] cmd,
                                      input bit vld, input logic [21:0] data);
        bit     accept;
        longint sum;
        if (!en) return;
        accept = st && !mPending;
        if (mPending) begin
            mCount++;
            if (mCount == mLat) mResult = mNewRes;
            if (mCount == mLat + 1) mPending = 0;
        end
        if (accept && cmd == 2'd2) begin
            floatOf(mAcc, mNewRes, mLat);
            mPending = 1;
            mCount   = 1;
        end
        if (accept && cmd == 2'd0) begin
            mAcc = 0;
            mOvf = 0;
        end else if (mArmed && vld) begin
            sum = longint'(mAcc) + longint'($signed(data));
            if (sum > 64'sd2147483647 || sum < -64'sd2147483648) begin
                mOvf = 1;
`ifdef SATURATE_EN
                sum = (sum > 0) ? 64'sd2147483647 : -64'sd2147483648;
`endif
            end
            mAcc = sum[31:0];
        end
        if (accept && cmd == 2'd1) mArmed = 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("result",   result,            mResult);
        checkOutput("done",     {31'b0, done},     {31'b0, mPending && mCount == mLat});
        checkOutput("busy",     {31'b0, busy},     {31'b0, mPending});
        checkOutput("armed",    {31'b0, armed},    {31'b0, mArmed});
        checkOutput("overflow", {31'b0, overflow}, {31'b0, mOvf});
    endtask

    task automatic applyStimulus(input bit en, input bit st, input logic [1:0] cmd,
                                 input bit vld, input logic [21:0] data);
        clkEn   = en;
        start   = st;
        n       = cmd;
        inValid = vld;
        inData  = data;
        modelStep(en, st, cmd, vld, data);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic resetStep();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkAll();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1, 0, 2'd0, 0, 22'h0);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 64 && mPending; i++) applyStimulus(1, 0, 2'd0, 0, 22'h0);
    endtask

    initial begin
        logic [21:0] d;
        bit          en;
        bit          st;
        bit          vld;
        logic [1:0]  cmd;

        rst = 1'b1; clkEn = 1'b0; start = 1'b0; n = 2'd0; inValid = 1'b0; inData = 22'h0;
        modelReset();
        resetStep();
        checkOutput("reset_result", result, 32'h0);

        // Zero read: done two cycles after READ
        applyStimulus(1, 1, 2'd0, 0, 22'h0);
        applyStimulus(1, 1, 2'd2, 0, 22'h0);
        waitIdle();
        checkOutput("zero_read", result, 32'h0000_0000);

        // Basic sum 1.0 + 0.5, with a READ issued mid-NORM that must be ignored
        applyStimulus(1, 1, 2'd1, 0, 22'h0);
        applyStimulus(1, 0, 2'd0, 1, 22'h010000);
        applyStimulus(1, 0, 2'd0, 1, 22'h008000);
        applyStimulus(1, 1, 2'd2, 0, 22'h0);
        idle(4);
        applyStimulus(1, 1, 2'd2, 0, 22'h0);
        waitIdle();
        checkOutput("sum_1p5", result, 32'h3FC0_0000);
        checkOutput("sum_ovf", {31'b0, overflow}, 32'h0);

        // CLEAR collides with a valid sample: sample is dropped
        applyStimulus(1, 1, 2'd0, 1, 22'h012345);
        applyStimulus(1, 1, 2'd2, 0, 22'h0);
        waitIdle();
        checkOutput("clear_wins", result, 32'h0);

        // Negative -2.0, with clk_en low for 5 cycles mid-NORM
        applyStimulus(1, 1, 2'd0, 0, 22'h0);
        applyStimulus(1, 1, 2'd1, 0, 22'h0);
        applyStimulus(1, 0, 2'd0, 1, 22'h3E0000);
        applyStimulus(1, 1, 2'd2, 0, 22'h0);
        idle(3);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 2'd0, 1, 22'h000100);
        waitIdle();
        checkOutput("neg_2p0", result, 32'hC000_0000);

        // Overflow: 2048 samples of 16.0
        applyStimulus(1, 1, 2'd0, 0, 22'h0);
        for (int i = 0; i < 2048; i++) applyStimulus(1, 0, 2'd0, 1, 22'h100000);
        checkOutput("ovf_flag", {31'b0, overflow}, 32'h1);
        applyStimulus(1, 1, 2'd2, 0, 22'h0);
        waitIdle();
`ifdef SATURATE_EN
        checkOutput("ovf_result", result, 32'h46FF_FFFF);
`else
        checkOutput("ovf_result", result, 32'hC700_0000);
`endif

        // Reset mid-NORM aborts the conversion
        applyStimulus(1, 1, 2'd0, 0, 22'h0);
        applyStimulus(1, 0, 2'd0, 1, 22'h000003);
        applyStimulus(1, 1, 2'd2, 0, 22'h0);
        idle(4);
        resetStep();
        idle(40);
        checkOutput("rst_result", result, 32'h0);

        // Randomized commands, samples and enables
        applyStimulus(1, 1, 2'd1, 0, 22'h0);
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            st  = ($urandom_range(0, 11) == 0);
            cmd = 2'($urandom_range(0, 3));
            vld = ($urandom_range(0, 2) != 0);
            d   = 22'($urandom);
            if ($urandom_range(0, 1) == 1) d = 22'($signed(d) >>> 6);
            applyStimulus(en, st, cmd, vld, d);
        end
        waitIdle();
        applyStimulus(1, 1, 2'd2, 0, 22'h0);
        waitIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
